// File: rtl/ex_flag_stage.sv
// EX-stage flag unit: Z/V/N flag register, branch resolution with same-cycle
// flag bypass, and the EX/MEM result latch with stall/flush control.
module ex_flag_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [DW-1:0] alu_res,
    input  logic          stall,
    input  logic          flush,
    input  logic          br_valid,
    input  logic [2:0]    br_cond,
    output logic [DW-1:0] mem_res,
    output logic [3:0]    mem_opcode,
    output logic          mem_valid,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          br_taken
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    localparam logic [2:0] BC_NE = 3'b000;
    localparam logic [2:0] BC_EQ = 3'b001;
    localparam logic [2:0] BC_GT = 3'b010;
    localparam logic [2:0] BC_LT = 3'b011;
    localparam logic [2:0] BC_GE = 3'b100;
    localparam logic [2:0] BC_LE = 3'b101;
    localparam logic [2:0] BC_OV = 3'b110;

    logic          commit;
    logic          wr_vn;
    logic          wr_z;
    logic          is_sub;
    logic [DW-1:0] s;
    logic          z_new;
    logic          v_new;
    logic          n_new;
    logic          upd_z;
    logic          upd_vn;
    logic          fz;
    logic          fv;
    logic          fn;
    logic          cond_hit;

    // flush outranks stall: a flushed instruction never commits
    assign commit = ex_valid & ~stall & ~flush;

    always_comb begin
        wr_vn = 1'b0;
        wr_z  = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB: begin
                wr_vn = 1'b1;
                wr_z  = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z = 1'b1;
            default: ;
        endcase
    end

    // V comes from a private wrapping sum so ALU saturation cannot hide it
    assign is_sub = (opcode == OP_SUB);
    assign s      = is_sub ? (A - B) : (A + B);
    assign v_new  = is_sub ? ((A[DW-1] ^ B[DW-1]) & (s[DW-1] ^ A[DW-1]))
                           : (~(A[DW-1] ^ B[DW-1]) & (s[DW-1] ^ A[DW-1]));
    assign z_new  = (alu_res == '0);
    assign n_new  = alu_res[DW-1];

    assign upd_z  = commit & wr_z;
    assign upd_vn = commit & wr_vn;

    assign fz = upd_z  ? z_new : flag_z;
    assign fv = upd_vn ? v_new : flag_v;
    assign fn = upd_vn ? n_new : flag_n;

    always_comb begin
        cond_hit = 1'b1;
        case (br_cond)
            BC_NE:   cond_hit = ~fz;
            BC_EQ:   cond_hit = fz;
            BC_GT:   cond_hit = ~fz & ~fn;
            BC_LT:   cond_hit = fn;
            BC_GE:   cond_hit = fz | ~fn;
            BC_LE:   cond_hit = fn | fz;
            BC_OV:   cond_hit = fv;
            default: cond_hit = 1'b1;
        endcase
    end

    assign br_taken = ~rst & br_valid & cond_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (upd_z) flag_z <= z_new;
            if (upd_vn) begin
                flag_v <= v_new;
                flag_n <= n_new;
            end
        end
    end

    // flushed slots keep stale res/opcode; only mem_valid matters downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_res    <= '0;
            mem_opcode <= '0;
            mem_valid  <= 1'b0;
        end else if (flush) begin
            mem_valid  <= 1'b0;
        end else if (!stall) begin
            mem_res    <= alu_res;
            mem_opcode <= opcode;
            mem_valid  <= ex_valid;
        end
    end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Sits directly downstream of the 16-bit ALU in the EX stage. It consumes the ALU result, opcode and operands.
- Computes the Z/V/N condition flags and holds them in the processor flag register.
- Resolves 3-bit branch conditions, with same-cycle bypass of newly computed flags.
- Registers the ALU result into the EX/MEM pipeline latch, with stall and flush control.

Parameters:
- DW, 16, datapath width; only 16 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  EX stage holds a real instruction this cycle.
- opcode  in  4  opcode of the EX instruction, the same encoding the ALU uses.
- A  in  16  ALU operand A.
- B  in  16  ALU operand B.
- alu_res  in  16  ALU result; may be saturated.
- stall  in  1  hold the EX/MEM latch and the flags.
- flush  in  1  kill the EX instruction.
- br_valid  in  1  a branch is being resolved this cycle.
- br_cond  in  3  branch condition code.
- mem_res  out  16  registered result.
- mem_opcode  out  4  registered opcode.
- mem_valid  out  1  registered valid.
- flag_z  out  1  registered zero flag.
- flag_v  out  1  registered overflow flag.
- flag_n  out  1  registered negative flag.
- br_taken  out  1  combinational branch decision.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous active-high.
  - While rst is high: mem_res=0, mem_opcode=0, mem_valid=0, flag_z=0, flag_v=0, flag_n=0.
  - br_taken=0 while rst is high.
  - Reset asserted mid-instruction discards that instruction. No flag survives.
- Commit condition: commit = ex_valid & ~stall & ~flush.
  - flush has priority over stall.
- EX/MEM latch:
  - On a clock edge with flush=1: mem_valid<=0; mem_res and mem_opcode don't-care, implemented as hold.
  - Else with stall=1: all latch registers hold.
  - Else: mem_res<=alu_res, mem_opcode<=opcode, mem_valid<=ex_valid.
  - Latency is 1 cycle.
- Flag write set, applied only when commit=1:
  - ADD 0000 and SUB 0001 write Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 write Z only; V and N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, 11xx) write no flags.
- Flag computation:
  - Z = (alu_res == 0).
  - N = alu_res[15].
  - V is computed from A and B with an internal wrapping 16-bit sum or difference S, not from alu_res, so saturation in the ALU does not mask it.
    - ADD: V = (A[15]==B[15]) & (S[15]!=A[15]).
    - SUB (A-B): V = (A[15]!=B[15]) & (S[15]!=A[15]).
- Flag bypass: the effective flags (fz, fv, fn) used for branch resolution are selected per flag.
  - A flag uses the newly computed value if commit=1 and the opcode writes that flag.
  - Otherwise it uses the registered value.
  - This lets a branch resolve in the same cycle as the flag-setting instruction ahead of it.
- Branch decision: br_taken = br_valid & cond(br_cond), where cond(br_cond) is:
  - 000 NE: ~fz.
  - 001 EQ: fz.
  - 010 GT: ~fz & ~fn.
  - 011 LT: fn.
  - 100 GE: fz | (~fz & ~fn).
  - 101 LE: fn | fz.
  - 110 OV: fv.
  - 111 unconditional: 1.
  - br_valid=0 forces br_taken=0.
- Boundary conditions:
  - A stalled or flushed instruction never changes the flags and never bypasses.
  - Back-to-back flag writers: each edge takes the newest values.
  - Stall held for N cycles keeps every output constant.

Test Plan:
- Reset mid-stream:
  - Stimulus: commit ADD 0x0001+0xFFFF (alu_res=0x0000) so flag_z=1; then pulse rst mid-cycle.
  - Required: all outputs go to 0 immediately, before the next clk edge; mem_valid=0.
- Overflow on ADD:
  - Stimulus: A=0x7FFF, B=0x0001, alu_res=0x7FFF (saturated), ex_valid=1.
  - Required: next edge flag_v=1, flag_n=0, flag_z=0, mem_res=0x7FFF, mem_valid=1.
- Partial flag write:
  - Stimulus: after the overflow case, commit XOR with A=B=0x1234, alu_res=0.
  - Required: flag_z=1, flag_v stays 1, flag_n stays 0.
- Bypass:
  - Stimulus: SUB A=5, B=5, alu_res=0, ex_valid=1, br_valid=1, br_cond=001 in the same cycle.
  - Required: br_taken=1 before the edge; flag_z=1 after.
  - Repeat with stall=1: br_taken follows the old flag_z, and flags are unchanged after the edge.
- Stall/flush priority:
  - Stimulus: stall=1 and flush=1 together with ADD 0x8000+0x8000.
  - Required: mem_valid=0 after the edge; flags unchanged; the stall alone would have held mem_valid at its prior value 1.
- No-flag opcodes:
  - Stimulus: LLB (1010) and PADDSB (0111) with alu_res=0.
  - Required: flags unchanged, mem_res=0, mem_opcode tracks the opcode, br_cond=111 gives br_taken=1.
